// File: rtl/music_pkg.sv
// Shared types and song-table field layout for the song sequencer and its ROM.
// Entry layout is {dur[3:0], note[5:0]}; dur of zero marks the end of a song.
package music_pkg;

    localparam int ENTRY_W = 10;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 4;

    localparam logic [DUR_W-1:0]  END_DUR   = '0;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] e);
        return e[NOTE_W-1:0];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1 -: DUR_W];
    endfunction

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [DUR_W-1:0] d,
                                                      input logic [NOTE_W-1:0] n);
        return {d, n};
    endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song table lookup. SONG_ID 0 is the bring-up table; SONG_ID 1 is
// an ascending run with no end marker, so playback ends by address wrap.
module song_rom
    import music_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int SONG_ID = 0
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] entry
);

    generate
        if (SONG_ID == 1) begin : g_song1
            always_comb begin
                entry = make_entry(4'd1, NOTE_W'(24) + NOTE_W'(addr));
            end
        end else begin : g_song0
            always_comb begin
                entry = make_entry(END_DUR, REST_NOTE);
                case (int'(addr))
                    0:       entry = make_entry(4'd2, 6'd27);
                    1:       entry = make_entry(4'd1, REST_NOTE);
                    2:       entry = make_entry(4'd1, 6'd27);
                    3:       entry = make_entry(4'd4, 6'd31);
                    default: entry = make_entry(END_DUR, REST_NOTE);
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/song_sequencer.sv
// Walks the song table and drives the tone generator's fullnote input, holding
// each note for dur*TICKS_PER_BEAT cycles including a silent LOAD cycle and gap.
module song_sequencer
    import music_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 4,
    parameter int GAP_TICKS      = 1,
    parameter int ADDR_W         = 4,
    parameter int SONG_ID        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [7:0]        fullnote,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int CNT_W = (15 * TICKS_PER_BEAT > 1) ? $clog2(15 * TICKS_PER_BEAT) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic HAS_GAP = (GAP_TICKS > 0);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_next;
    logic               r_wrap;
    logic               w_wrap_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [7:0]         r_fullnote;
    logic [7:0]         w_fullnote_next;
    logic               r_busy;
    logic               w_busy_next;
    logic               r_done;
    logic               w_done_next;

    logic [ENTRY_W-1:0] w_entry;
    logic [DUR_W-1:0]   w_dur;
    logic [NOTE_W-1:0]  w_note;
    logic               w_end;
    logic               w_last_addr;
    logic [CNT_W-1:0]   w_play_load;

    song_rom #(
        .ADDR_W  (ADDR_W),
        .SONG_ID (SONG_ID)
    ) u_rom (
        .addr  (r_addr),
        .entry (w_entry)
    );

    assign w_dur       = entry_dur(w_entry);
    assign w_note      = entry_note(w_entry);
    // r_wrap marks that the address rolled over from the last entry: end of song.
    assign w_end       = (w_dur == END_DUR) || r_wrap;
    assign w_last_addr = (r_addr == {ADDR_W{1'b1}});
    // PLAY lasts counter+1 cycles, so the slot totals LOAD + PLAY + GAP = dur*TPB.
    assign w_play_load = CNT_W'(int'(w_dur) * TICKS_PER_BEAT - GAP_TICKS - 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wrap     <= 1'b0;
            r_cnt      <= '0;
            r_fullnote <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_wrap     <= w_wrap_next;
            r_cnt      <= w_cnt_next;
            r_fullnote <= w_fullnote_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wrap_next  = r_wrap;
        w_cnt_next   = r_cnt;
        if (r_state != ST_IDLE && stop) begin
            w_state_next = ST_IDLE;
            w_addr_next  = '0;
            w_wrap_next  = 1'b0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        w_state_next = ST_LOAD;
                        w_addr_next  = '0;
                        w_wrap_next  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_end) begin
                        if (loop_en) begin
                            w_addr_next = '0;
                            w_wrap_next = 1'b0;
                        end else begin
                            w_state_next = ST_DONE;
                        end
                    end else begin
                        w_cnt_next   = w_play_load;
                        w_state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (r_cnt == '0) begin
                        if (HAS_GAP) begin
                            w_state_next = ST_GAP;
                            w_cnt_next   = GAP_LOAD;
                        end else begin
                            w_state_next = ST_LOAD;
                            w_addr_next  = r_addr + 1'b1;
                            w_wrap_next  = w_last_addr;
                        end
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_LOAD;
                        w_addr_next  = r_addr + 1'b1;
                        w_wrap_next  = w_last_addr;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        w_fullnote_next = '0;
        if (w_state_next == ST_PLAY) begin
            w_fullnote_next = (r_state == ST_LOAD) ? {{(8 - NOTE_W){1'b0}}, w_note} : r_fullnote;
        end
        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (w_state_next == ST_DONE);
    end

    assign fullnote = r_fullnote;
    assign busy     = r_busy;
    assign done     = r_done;
    assign note_idx = r_addr;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed timelines on table 0 plus randomized
// start/stop/loop traffic checked against a slot/offset model of each song.
module tb_song_sequencer;

    localparam int TPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;

    logic [7:0] fn0, fn1, fn2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [3:0] idx0, idx1;
    logic [2:0] idx2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(1), .ADDR_W(4), .SONG_ID(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .fullnote(fn0), .busy(busy0), .done(done0), .note_idx(idx0));

    song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(0), .ADDR_W(4), .SONG_ID(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .fullnote(fn1), .busy(busy1), .done(done1), .note_idx(idx1));

    song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(1), .ADDR_W(3), .SONG_ID(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .fullnote(fn2), .busy(busy2), .done(done2), .note_idx(idx2));

    // Reference songs: per model, duration/note of each entry, song length and gap.
    int tdur[3][16];
    int tnote[3][16];
    int slen[3];
    int gapt[3];
    // Model position: mode 0 idle, 1 inside a song slot, 2 done cycle.
    int m_mode[3];
    int m_idx[3];
    int m_off[3];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected dut0 timeline for one un-looped play of table 0, c=1 is the LOAD of e0.
    function automatic int exp_fn_gap1(int c);
        if (c >= 2 && c <= 7) return 27;
        if (c >= 14 && c <= 15) return 27;
        if (c >= 18 && c <= 31) return 31;
        return 0;
    endfunction

    function automatic int exp_fn_gap0(int c);
        if (c >= 2 && c <= 8) return 27;
        if (c >= 14 && c <= 16) return 27;
        if (c >= 18 && c <= 32) return 31;
        return 0;
    endfunction

    function automatic int exp_idx_t0(int c);
        if (c < 9) return 0;
        if (c < 13) return 1;
        if (c < 17) return 2;
        if (c < 33) return 3;
        return 4;
    endfunction

    function automatic bit m_terminal(int k);
        if (m_idx[k] >= slen[k]) return 1'b1;
        return tdur[k][m_idx[k]] == 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_mode[k] = 0;
            m_idx[k]  = 0;
            m_off[k]  = 0;
        end
    endtask

    task automatic model_step(int k, bit s, bit p, bit l);
        if (m_mode[k] != 0 && p) begin
            m_mode[k] = 0;
            m_idx[k]  = 0;
            m_off[k]  = 0;
        end else if (m_mode[k] == 0) begin
            if (s && !p) begin
                m_mode[k] = 1;
                m_idx[k]  = 0;
                m_off[k]  = 0;
            end
        end else if (m_mode[k] == 2) begin
            m_mode[k] = 0;
        end else if (m_off[k] == 0 && m_terminal(k)) begin
            if (l) m_idx[k] = 0;
            else   m_mode[k] = 2;
        end else begin
            m_off[k]++;
            if (m_off[k] == tdur[k][m_idx[k]] * TPB) begin
                m_idx[k]++;
                m_off[k] = 0;
            end
        end
    endtask

    function automatic int m_fn(int k);
        if (m_mode[k] != 1 || m_terminal(k)) return 0;
        if (m_off[k] >= 1 && m_off[k] <= tdur[k][m_idx[k]] * TPB - 1 - gapt[k])
            return tnote[k][m_idx[k]];
        return 0;
    endfunction

    task automatic test_reset();
        #2;
        if (fn0 !== 8'd0 || fn1 !== 8'd0 || fn2 !== 8'd0) begin
            errors++; $display("FAIL reset_fullnote got %0d/%0d/%0d want 0", fn0, fn1, fn2);
        end
        checks++;
        if ({busy0, busy1, busy2, done0, done1, done2} !== 6'd0) begin
            errors++; $display("FAIL reset_busy_done got %b want 000000",
                               {busy0, busy1, busy2, done0, done1, done2});
        end
        checks++;
        if (idx0 !== 4'd0 || idx2 !== 3'd0) begin
            errors++; $display("FAIL reset_note_idx got %0d/%0d want 0", idx0, idx2);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        if (busy0 !== 1'b0 || fn0 !== 8'd0) begin
            errors++; $display("FAIL idle_after_reset busy %b fn %0d want 0 0", busy0, fn0);
        end
        checks++;
    endtask

    task automatic test_song();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (int'(fn0) !== exp_fn_gap1(c)) begin
                errors++; $display("FAIL song_fullnote c=%0d got %0d want %0d", c, fn0, exp_fn_gap1(c));
            end
            checks++;
            if (busy0 !== (c <= 34)) begin
                errors++; $display("FAIL song_busy c=%0d got %b want %b", c, busy0, c <= 34);
            end
            checks++;
            if (done0 !== (c == 34)) begin
                errors++; $display("FAIL song_done c=%0d got %b want %b", c, done0, c == 34);
            end
            checks++;
            if (c <= 34 && int'(idx0) !== exp_idx_t0(c)) begin
                errors++; $display("FAIL song_note_idx c=%0d got %0d want %0d", c, idx0, exp_idx_t0(c));
            end
            if (c <= 34) checks++;
            tick();
        end
    endtask

    task automatic test_loop();
        int want_idx;
        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done0 !== 1'b0) begin
                errors++; $display("FAIL loop_no_done c=%0d got %b want 0", c, done0);
            end
            checks++;
            want_idx = (c == 34) ? 0 : exp_idx_t0(c);
            if (c <= 34 && int'(idx0) !== want_idx) begin
                errors++; $display("FAIL loop_note_idx c=%0d got %0d want %0d", c, idx0, want_idx);
            end
            if (c <= 34) checks++;
            if (c >= 33 && c <= 35 && int'(fn0) !== ((c == 35) ? 27 : 0)) begin
                errors++; $display("FAIL loop_restart_note c=%0d got %0d want %0d", c, fn0, (c == 35) ? 27 : 0);
            end
            if (c >= 33 && c <= 35) checks++;
            tick();
        end
        loop_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if (busy0 !== 1'b0) begin
            errors++; $display("FAIL loop_stop_busy got %b want 0", busy0);
        end
        checks++;
    endtask

    task automatic test_stop();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if (fn0 !== 8'd0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL stop_idle fn %0d busy %b want 0 0", fn0, busy0);
        end
        checks++;
        for (int c = 0; c < 6; c++) begin
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL stop_no_done c=%0d done %b busy %b want 0 0", c, done0, busy0);
            end
            checks++;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (idx0 !== 4'd0 || busy0 !== 1'b1 || fn0 !== 8'd0) begin
            errors++; $display("FAIL restart_load idx %0d busy %b fn %0d want 0 1 0", idx0, busy0, fn0);
        end
        checks++;
        tick();
        if (fn0 !== 8'd27) begin
            errors++; $display("FAIL restart_note got %0d want 27", fn0);
        end
        checks++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_start_while_busy();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (int'(fn0) !== exp_fn_gap1(c)) begin
                errors++; $display("FAIL busy_start_fullnote c=%0d got %0d want %0d", c, fn0, exp_fn_gap1(c));
            end
            checks++;
            if (done0 !== (c == 34) || busy0 !== (c <= 34)) begin
                errors++; $display("FAIL busy_start_flags c=%0d done %b busy %b want %b %b",
                                   c, done0, busy0, c == 34, c <= 34);
            end
            checks++;
            start = (c == 10);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        if (fn0 !== 8'd27) begin
            errors++; $display("FAIL pre_reset_play got %0d want 27", fn0);
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (fn0 !== 8'd0 || busy0 !== 1'b0 || fn1 !== 8'd0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL async_reset fn %0d/%0d busy %b/%b want 0", fn0, fn1, busy0, busy1);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (fn0 !== 8'd0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle c=%0d fn %0d busy %b want 0 0", c, fn0, busy0);
            end
            checks++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        if (fn0 !== 8'd27 || busy0 !== 1'b1) begin
            errors++; $display("FAIL post_reset_start fn %0d busy %b want 27 1", fn0, busy0);
        end
        checks++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_gap0();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (int'(fn1) !== exp_fn_gap0(c)) begin
                errors++; $display("FAIL gap0_fullnote c=%0d got %0d want %0d", c, fn1, exp_fn_gap0(c));
            end
            checks++;
            if (done1 !== (c == 34) || busy1 !== (c <= 34)) begin
                errors++; $display("FAIL gap0_flags c=%0d done %b busy %b want %b %b",
                                   c, done1, busy1, c == 34, c <= 34);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_random();
        int a_fn, a_idx;
        bit a_busy, a_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            start   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            loop_en = $urandom_range(0, 1) != 0;
            @(posedge clk);
            for (int k = 0; k < 3; k++) model_step(k, start, stop, loop_en);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0:       begin a_fn = int'(fn0); a_busy = busy0; a_done = done0; a_idx = int'(idx0); end
                    1:       begin a_fn = int'(fn1); a_busy = busy1; a_done = done1; a_idx = int'(idx1); end
                    default: begin a_fn = int'(fn2); a_busy = busy2; a_done = done2; a_idx = int'(idx2); end
                endcase
                if (a_fn !== m_fn(k)) begin
                    errors++; $display("FAIL rand_fullnote dut%0d n=%0d got %0d want %0d", k, n, a_fn, m_fn(k));
                end
                checks++;
                if (a_busy !== (m_mode[k] != 0)) begin
                    errors++; $display("FAIL rand_busy dut%0d n=%0d got %b want %b", k, n, a_busy, m_mode[k] != 0);
                end
                checks++;
                if (a_done !== (m_mode[k] == 2)) begin
                    errors++; $display("FAIL rand_done dut%0d n=%0d got %b want %b", k, n, a_done, m_mode[k] == 2);
                end
                checks++;
                if (a_idx !== (m_idx[k] % slen[k])) begin
                    errors++; $display("FAIL rand_note_idx dut%0d n=%0d got %0d want %0d",
                                       k, n, a_idx, m_idx[k] % slen[k]);
                end
                checks++;
            end
        end
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                tdur[k][i]  = 0;
                tnote[k][i] = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            tdur[k][0] = 2; tnote[k][0] = 27;
            tdur[k][1] = 1; tnote[k][1] = 0;
            tdur[k][2] = 1; tnote[k][2] = 27;
            tdur[k][3] = 4; tnote[k][3] = 31;
            slen[k] = 16;
        end
        for (int i = 0; i < 8; i++) begin
            tdur[2][i]  = 1;
            tnote[2][i] = 24 + i;
        end
        slen[2] = 8;
        gapt[0] = 1;
        gapt[1] = 0;
        gapt[2] = 1;
        model_reset();

        test_reset();
        test_song();
        test_loop();
        test_stop();
        test_start_while_busy();
        test_async_reset();
        test_gap0();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream stage of the tone generator (`music`). It walks a song table and drives the tone generator's 8-bit `fullnote` input.
- Each table entry holds a 6-bit note code and a 4-bit duration in beats.
- The block holds each note for the exact beat-quantised time and inserts a short silent articulation gap between entries, so repeated notes stay distinct.
- Play is controlled by start/stop/loop signals from the top-level control logic.

Parameters:
- TICKS_PER_BEAT, 4, clk cycles per duration unit. Must be >= GAP_TICKS+2. Production value is set at top level.
- GAP_TICKS, 1, silent cycles at the end of every entry. 0 disables the gap.
- ADDR_W, 4, song table address width. SONG_LEN = 2**ADDR_W.
- SONG_ID, 0, selects the song table inside song_rom. Table 0 is the bring-up table.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to play from entry 0
- stop  in  1  abort playback, return to idle
- loop_en  in  1  restart at entry 0 instead of finishing (sampled at end of song)
- fullnote  out  8  {2'b00, note}. 0 = silence. Feeds the tone generator directly.
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the song finishes without looping
- note_idx  out  ADDR_W  address of the entry currently playing

Behaviour:
- Reset values (async, immediate): state=IDLE, fullnote=0, busy=0, done=0, note_idx=0, tick counter=0. Reset mid-song silences output within the same cycle.
- Table entry is 10 bits: {dur[3:0], note[5:0]}.
  - dur=0 is the end-of-song marker.
  - note=0 with dur>0 is a rest.
- States: IDLE, LOAD, PLAY, GAP, DONE. All outputs are registered.
- IDLE: fullnote=0. Start=1 and stop=0 -> LOAD with addr=0.
- LOAD (1 cycle): fullnote=0. Reads entry[addr].
  - dur=0, or addr wrapped past SONG_LEN-1: if loop_en, addr=0 and stay in LOAD; else -> DONE.
  - Otherwise: tick counter = dur*TICKS_PER_BEAT - GAP_TICKS - 2, then -> PLAY.
- PLAY: fullnote={2'b00,note}. Counter decrements each cycle. Leaves when counter=0: to GAP if GAP_TICKS>0, else to LOAD with addr+1.
- GAP: fullnote=0 for exactly GAP_TICKS cycles, then -> LOAD with addr+1.
- Slot length per non-terminal entry is exactly dur*TICKS_PER_BEAT cycles: LOAD 1 + PLAY (dur*TPB-GAP-1) + GAP.
- DONE (1 cycle): done=1, fullnote=0, then -> IDLE. busy is high in DONE.
- stop=1 in any non-IDLE state: next state IDLE, fullnote=0, addr=0, no done pulse. Stop has priority over every other transition.
- start while busy: ignored.
- start and stop together in IDLE: stop wins, stay in IDLE.
- Address wrap: after entry SONG_LEN-1, addr wraps to 0 and is treated as end of song, even with no dur=0 marker.
- Counter width: clog2(15*TICKS_PER_BEAT). Width is sized by parameter; no overflow is possible.
- note_idx updates on entry to LOAD.

Decomposition:
- Shared package `music_pkg`:
  - state enum
  - ENTRY_W=10, NOTE_W=6, DUR_W=4
  - END_DUR=0, REST_NOTE=0
  - entry field slice helpers
- Sub-module `song_rom` (params ADDR_W, SONG_ID; in addr; out entry[9:0]): combinational case table.
- Table 0 contents: e0={2,27}, e1={1,0}, e2={1,27}, e3={4,31}, e4={0,0}.
- The sequencer FSM and counters live in song_sequencer.

Test Plan (TPB=4, GAP=1, table 0; cycle 0 is the edge that samples start):
- Start pulse -> LOAD at cycle 1, then:
  - fullnote=27 during cycles 2-7, 0 at cycle 8 (gap);
  - rest entry gives 0 at cycles 9-12;
  - fullnote=27 at cycles 14-15;
  - fullnote=31 at cycles 18-31;
  - done=1 at cycle 34; busy falls at cycle 35.
- Same as above with loop_en=1 -> no done pulse; fullnote returns to 27 exactly two cycles after the e4 LOAD; note_idx sequence is 0,1,2,3,4,0.
- Stop asserted at cycle 5 -> fullnote=0 and busy=0 from cycle 6; no done pulse; a following start replays from e0.
- Start asserted at cycle 10 while busy -> no effect; the timeline is identical to the first scenario.
- Async rst pulse mid-PLAY (between edges) -> fullnote=0 and busy=0 immediately; stays idle after release until the next start.
- GAP_TICKS=0 variant -> e0 gives fullnote=27 for 7 cycles; LOAD cycles are the only silent cycles between notes.
